// File: rtl/serialin_pkg.sv
// Shared definitions for the serial-in scanner (and its serialout counterpart):
// state encoding and a constant-foldable clog2 helper.
package serialin_pkg;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_LOAD  = 2'd1,
      S_SHIFT = 2'd2,
      S_DONE  = 2'd3
   } state_e;

   // Usable in localparam expressions; returns 0 for v <= 1.
   function automatic int clog2(input int v);
      int r;
      r = 0;
      while ((1 << r) < v) r++;
      return r;
   endfunction

endpackage

// File: rtl/serialin_div.sv
// Tick generator: pulses tick once every CLK_DIV cycles while enabled,
// counter forced to zero while clr is high.
module serialin_div
   import serialin_pkg::*;
#(
   parameter int CLK_DIV = 16
) (
   input  logic clki,
   input  logic rst,
   input  logic en,
   input  logic clr,
   output logic tick
);

   localparam int CW = (clog2(CLK_DIV) < 1) ? 1 : clog2(CLK_DIV);
   localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

   logic [CW-1:0] cnt_q, cnt_d;

   assign tick = en & ~clr & (cnt_q == LAST);

   always_comb begin
      cnt_d = cnt_q;
      if (clr)
         cnt_d = '0;
      else if (en)
         cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
   end

   always_ff @(posedge clki or posedge rst) begin
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
   end

endmodule

// File: rtl/serialin.sv
// Scans a 74HC165-style PISO register and presents the captured word.
// Optional SERIALIN_DEBOUNCE_EN: accept a frame only if it repeats the previous one.
module serialin
   import serialin_pkg::*;
#(
   parameter int WIDTH   = 8,
   parameter int CLK_DIV = 16
) (
   input  logic             clki,
   input  logic             rst,
   input  logic             en,
   input  logic             sdata,
   output logic             sclk,
   output logic             sload_n,
   output logic [WIDTH-1:0] data_out,
   output logic             data_valid,
   output logic             busy
);

   localparam int IW = clog2(WIDTH) + 1;
   localparam logic [IW-1:0] LAST_BIT = IW'(WIDTH - 1);

   state_e           state_q, state_d;
   logic             phase_q, phase_d;
   logic [IW-1:0]    bit_q, bit_d;
   logic [WIDTH-1:0] shift_q, shift_d;
   logic [WIDTH-1:0] dout_q, dout_d;
   logic             dv_q, dv_d;
   logic             sclk_q, sclk_d;
   logic             sload_n_q, sload_n_d;
   logic             busy_q, busy_d;
   logic             tick, div_clr, accept;

   // Divider also held in DONE so each LOAD gets its full two ticks.
   assign div_clr = (state_q == S_IDLE) || (state_q == S_DONE);

   serialin_div #(.CLK_DIV(CLK_DIV)) u_div (
      .clki (clki),
      .rst  (rst),
      .en   (1'b1),
      .clr  (div_clr),
      .tick (tick)
   );

`ifdef SERIALIN_DEBOUNCE_EN
   logic [WIDTH-1:0] prev_q;

   assign accept = (shift_q == prev_q);

   always_ff @(posedge clki or posedge rst) begin
      if (rst)                     prev_q <= '0;
      else if (state_q == S_DONE)  prev_q <= shift_q;
   end
`else
   assign accept = 1'b1;
`endif

   always_comb begin
      state_d = state_q;
      phase_d = phase_q;
      bit_d   = bit_q;
      shift_d = shift_q;
      dout_d  = dout_q;
      dv_d    = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (en) begin
               state_d = S_LOAD;
               phase_d = 1'b0;
            end
         end
         S_LOAD: begin
            if (tick) begin
               if (phase_q) begin
                  state_d = S_SHIFT;
                  phase_d = 1'b0;
                  bit_d   = '0;
               end else begin
                  phase_d = 1'b1;
               end
            end
         end
         S_SHIFT: begin
            if (tick) begin
               if (!phase_q) begin
                  // Sample on the last cycle of the low phase, just before sclk rises.
                  shift_d = (shift_q << 1) | WIDTH'(sdata);
                  phase_d = 1'b1;
               end else begin
                  phase_d = 1'b0;
                  if (bit_q == LAST_BIT) state_d = S_DONE;
                  else                   bit_d   = bit_q + 1'b1;
               end
            end
         end
         S_DONE: begin
            if (accept) begin
               dout_d = shift_q;
               dv_d   = 1'b1;
            end
            state_d = en ? S_LOAD : S_IDLE;
            phase_d = 1'b0;
            bit_d   = '0;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Pin outputs are registered from next state so they never glitch.
   always_comb begin
      sclk_d    = (state_d == S_SHIFT) && phase_d;
      sload_n_d = (state_d != S_LOAD);
      busy_d    = (state_d == S_LOAD) || (state_d == S_SHIFT);
   end

   always_ff @(posedge clki or posedge rst) begin
      if (rst) begin
         state_q   <= S_IDLE;
         phase_q   <= 1'b0;
         bit_q     <= '0;
         shift_q   <= '0;
         dout_q    <= '0;
         dv_q      <= 1'b0;
         sclk_q    <= 1'b0;
         sload_n_q <= 1'b1;
         busy_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         phase_q   <= phase_d;
         bit_q     <= bit_d;
         shift_q   <= shift_d;
         dout_q    <= dout_d;
         dv_q      <= dv_d;
         sclk_q    <= sclk_d;
         sload_n_q <= sload_n_d;
         busy_q    <= busy_d;
      end
   end

   assign sclk       = sclk_q;
   assign sload_n    = sload_n_q;
   assign data_out   = dout_q;
   assign data_valid = dv_q;
   assign busy       = busy_q;

endmodule
